// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared 640x480@60 timing defaults, coordinate and RGB332 types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_PIPE_DELAY = 2;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Test-pattern bar number: eight 80-pixel-wide vertical bars.
    function automatic logic [2:0] bar_index(input logic [9:0] x);
        logic [9:0] q;
        q = x / 10'd80;
        return q[2:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// Module      : vga_delay_line
// Description : WIDTH x DEPTH shift register with synchronous reset value;
//               DEPTH = 0 degenerates to a wire.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused_ok;
            assign w_unused_ok = clk ^ resetN;
            assign dout        = din;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!resetN) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RESET_VAL;
                    end
                end else begin
                    r_stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA timing generator and pixel output stage. Define
//               VGA_TEST_PATTERN_EN to replace RGBIn with eight colour bars.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic               clk,
    input  logic               resetN,
    output logic [COORD_W-1:0] pixelX,
    output logic [COORD_W-1:0] pixelY,
    output logic               frameTick,
    input  logic [7:0]         RGBIn,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               hSync,
    output logic               vSync,
    output logic               blankN
);

    localparam coord_t c_H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t c_V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t c_H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t c_V_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t c_HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t c_HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t c_VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t c_VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Delay payload: {visible, hSyncRaw, vSyncRaw[, bar]}; reset = blank, syncs idle.
`ifdef VGA_TEST_PATTERN_EN
    localparam int                 c_DLY_W   = 6;
    localparam logic [c_DLY_W-1:0] c_DLY_RST = 6'b011_000;
`else
    localparam int                 c_DLY_W   = 3;
    localparam logic [c_DLY_W-1:0] c_DLY_RST = 3'b011;
`endif

    coord_t             r_hCount;
    coord_t             r_vCount;
    logic               w_visible;
    logic               w_hSyncRaw;
    logic               w_vSyncRaw;
    logic [c_DLY_W-1:0] w_dlyIn;
    logic [c_DLY_W-1:0] w_dlyOut;
    logic               w_dVisible;
    logic               w_dHSync;
    logic               w_dVSync;
    rgb332_t            w_rgb;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_hCount <= '0;
            r_vCount <= '0;
        end else if (r_hCount == c_H_LAST) begin
            r_hCount <= '0;
            r_vCount <= (r_vCount == c_V_LAST) ? '0 : r_vCount + 1'b1;
        end else begin
            r_hCount <= r_hCount + 1'b1;
        end
    end

    assign pixelX    = r_hCount;
    assign pixelY    = r_vCount;
    assign frameTick = (r_hCount == '0) && (r_vCount == c_V_ACT);

    assign w_visible  = (r_hCount < c_H_ACT) && (r_vCount < c_V_ACT);
    assign w_hSyncRaw = !((r_hCount >= c_HS_FIRST) && (r_hCount <= c_HS_LAST));
    assign w_vSyncRaw = !((r_vCount >= c_VS_FIRST) && (r_vCount <= c_VS_LAST));

    assign w_dlyIn[c_DLY_W-1 -: 3] = {w_visible, w_hSyncRaw, w_vSyncRaw};

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar;
    logic       w_unused_rgb;

    assign w_dlyIn[2:0] = bar_index(r_hCount[9:0]);
    assign w_bar        = w_dlyOut[2:0];
    assign w_rgb        = {{3{w_bar[2]}}, {3{w_bar[1]}}, {2{w_bar[0]}}};
    assign w_unused_rgb = ^RGBIn;
`else
    assign w_rgb = rgb332_t'(RGBIn);
`endif

    vga_delay_line #(
        .WIDTH     (c_DLY_W),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (c_DLY_RST)
    ) u_delay (
        .clk    (clk),
        .resetN (resetN),
        .din    (w_dlyIn),
        .dout   (w_dlyOut)
    );

    assign w_dVisible = w_dlyOut[c_DLY_W-1];
    assign w_dHSync   = w_dlyOut[c_DLY_W-2];
    assign w_dVSync   = w_dlyOut[c_DLY_W-3];

    // 3-3-2 to 4-4-4 expansion by MSB replication; blanked pixels drive black.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            blankN <= 1'b0;
            hSync  <= 1'b1;
            vSync  <= 1'b1;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else begin
            blankN <= w_dVisible;
            hSync  <= w_dHSync;
            vSync  <= w_dVSync;
            if (w_dVisible) begin
                red   <= {w_rgb.r, w_rgb.r[2]};
                green <= {w_rgb.g, w_rgb.g[2]};
                blue  <= {w_rgb.b, w_rgb.b};
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Directed self-checking bench for vga_sync_gen. Vertical timing
//               is shortened to 15 lines per frame; horizontal is nominal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_sync_gen;

    localparam int HT  = 800;
    localparam int VA  = 8;
    localparam int VT  = 15;
    localparam int LAT = 3;
    localparam int FRAME = HT * VT;

    logic        clk    = 1'b0;
    logic        resetN = 1'b0;
    logic [7:0]  RGBIn  = 8'h00;
    logic [10:0] pixelX, pixelY;
    logic        frameTick;
    logic [3:0]  red, green, blue;
    logic        hSync, vSync, blankN;

    int n_pass  = 0;
    int n_total = 0;
    int t       = 0;
    bit toggle_rgb = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .V_ACTIVE (VA),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .pixelX    (pixelX),
        .pixelY    (pixelY),
        .frameTick (frameTick),
        .RGBIn     (RGBIn),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hSync     (hSync),
        .vSync     (vSync),
        .blankN    (blankN)
    );

    task automatic tick();
        @(negedge clk);
        t++;
        if (toggle_rgb) RGBIn = 8'($urandom);
    endtask

    task automatic wait_xy(input int x, input int y, output bit ok);
        int n = 0;
        while (!(pixelX == 11'(x) && pixelY == 11'(y)) && n < FRAME + 10) begin
            tick();
            n++;
        end
        ok = (n < FRAME + 10);
    endtask

    // Expected output visibility for the pixel sampled LAT clocks ago.
    function automatic logic exp_vis(input int tt);
        int s;
        if (tt < LAT) return 1'b0;
        s = tt - LAT;
        return ((s % HT) < 640) && (((s / HT) % VT) < VA);
    endfunction

    task automatic test_reset();
        logic [11:0] exp_first;
`ifdef VGA_TEST_PATTERN_EN
        exp_first = 12'h000;
`else
        exp_first = 12'hF00;
`endif
        resetN = 1'b0;
        RGBIn  = 8'hE0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({pixelX, pixelY, frameTick, hSync, vSync, blankN, red, green, blue}
            !== {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000})
            $display("FAIL reset_state: got x=%0d y=%0d ft=%b hs=%b vs=%b bn=%b rgb=%h, expected 0 0 0 1 1 0 000",
                     pixelX, pixelY, frameTick, hSync, vSync, blankN, {red, green, blue});
        else n_pass++;

        resetN = 1'b1;
        t = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_total++;
            if (pixelX !== 11'(k) || pixelY !== 11'd0)
                $display("FAIL count_start: got x=%0d y=%0d, expected x=%0d y=0", pixelX, pixelY, k);
            else n_pass++;
            n_total++;
            if (blankN !== (k >= LAT) || hSync !== 1'b1 || vSync !== 1'b1)
                $display("FAIL release_ctl k=%0d: got bn=%b hs=%b vs=%b, expected bn=%b hs=1 vs=1",
                         k, blankN, hSync, vSync, (k >= LAT));
            else n_pass++;
            if (k == LAT) begin
                n_total++;
                if ({red, green, blue} !== exp_first)
                    $display("FAIL first_pixel: got %h, expected %h", {red, green, blue}, exp_first);
                else n_pass++;
            end
        end
    endtask

    task automatic test_color(input logic [7:0] rgb, input logic [11:0] exp_rgb);
        int errs = 0;
        bit ok;
        RGBIn = rgb;
        repeat (LAT) tick();
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if ({blankN, red, green, blue} !== (exp_vis(t) ? {1'b1, exp_rgb} : 13'h0)) errs++;
        end
        n_total++;
        if (errs != 0) $display("FAIL color_scan_%h: got %0d bad pixels, expected 0", rgb, errs);
        else n_pass++;

        wait_xy(LAT + 639, 0, ok);
        n_total++;
        if (!ok || blankN !== 1'b1 || {red, green, blue} !== exp_rgb)
            $display("FAIL color_x639: got ok=%b bn=%b rgb=%h, expected 1 1 %h", ok, blankN, {red, green, blue}, exp_rgb);
        else n_pass++;
        tick();
        n_total++;
        if (blankN !== 1'b0 || {red, green, blue} !== 12'h000)
            $display("FAIL color_x640: got bn=%b rgb=%h, expected 0 000", blankN, {red, green, blue});
        else n_pass++;
        wait_xy(LAT + 10, VA, ok);
        n_total++;
        if (!ok || blankN !== 1'b0 || {red, green, blue} !== 12'h000)
            $display("FAIL color_line_va: got ok=%b bn=%b rgb=%h, expected 1 0 000", ok, blankN, {red, green, blue});
        else n_pass++;
    endtask

    task automatic test_hsync();
        bit ok;
        int n;
        int low;
        wait_xy(0, 1, ok);
        n = 0;
        do begin tick(); n++; end while (hSync !== 1'b0 && n < 1000);
        n_total++;
        if (!ok || n != 659) $display("FAIL hsync_fall: got %0d clocks (ok=%b), expected 659", n, ok);
        else n_pass++;
        low = 0;
        while (hSync === 1'b0 && low < 1000) begin tick(); low++; end
        n_total++;
        if (low != 96) $display("FAIL hsync_width: got %0d, expected 96", low);
        else n_pass++;
        n = low;
        while (hSync !== 1'b0 && n < 2000) begin tick(); n++; end
        n_total++;
        if (n != HT) $display("FAIL hsync_period: got %0d, expected %0d", n, HT);
        else n_pass++;
    endtask

    task automatic test_frames();
        int n = 0;
        int pulses = 0;
        int first_at = 0;
        int last_at = 0;
        int vs_low = 0;
        while (frameTick !== 1'b1 && n < FRAME + 10) begin tick(); n++; end
        n_total++;
        if (frameTick !== 1'b1 || pixelY !== 11'(VA) || pixelX !== 11'd0)
            $display("FAIL frame_tick_pos: got ft=%b x=%0d y=%0d, expected 1 0 %0d", frameTick, pixelX, pixelY, VA);
        else n_pass++;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            tick();
            if (vSync === 1'b0) vs_low++;
            if (i == 1) begin
                n_total++;
                if (frameTick !== 1'b0) $display("FAIL frame_tick_width: got %b, expected 0", frameTick);
                else n_pass++;
            end
            if (frameTick === 1'b1) begin
                pulses++;
                if (first_at == 0) first_at = i;
                last_at = i;
                n_total++;
                if (pixelY !== 11'(VA)) $display("FAIL frame_tick_line: got %0d, expected %0d", pixelY, VA);
                else n_pass++;
            end
        end
        n_total++;
        if (pulses != 2 || first_at != FRAME || last_at != 2 * FRAME)
            $display("FAIL frame_period: got pulses=%0d at %0d,%0d, expected 2 at %0d,%0d",
                     pulses, first_at, last_at, FRAME, 2 * FRAME);
        else n_pass++;
        n_total++;
        if (vs_low != 2 * 1600) $display("FAIL vsync_width: got %0d, expected %0d", vs_low, 2 * 1600);
        else n_pass++;
    endtask

    task automatic test_midframe_reset();
        bit ok;
        int n;
        wait_xy(300, 5, ok);
        resetN = 1'b0;
        tick();
        n_total++;
        if (!ok || {pixelX, pixelY, frameTick, hSync, vSync, blankN, red, green, blue}
            !== {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000})
            $display("FAIL mid_reset_state: got ok=%b x=%0d y=%0d ft=%b hs=%b vs=%b bn=%b rgb=%h, expected 1 0 0 0 1 1 0 000",
                     ok, pixelX, pixelY, frameTick, hSync, vSync, blankN, {red, green, blue});
        else n_pass++;
        resetN = 1'b1;
        t = 0;
        n = 0;
        do begin tick(); n++; end while (hSync !== 1'b0 && n < 1000);
        n_total++;
        if (n != 659) $display("FAIL mid_reset_hsync: got %0d, expected 659", n);
        else n_pass++;
        while (vSync !== 1'b0 && n < 9000) begin tick(); n++; end
        n_total++;
        if (n != 10 * HT + LAT) $display("FAIL mid_reset_vsync: got %0d, expected %0d", n, 10 * HT + LAT);
        else n_pass++;
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        bit ok;
        toggle_rgb = 1'b1;
        wait_xy(LAT + 80, 1, ok);
        n_total++;
        if (!ok || {red, green, blue} !== 12'h00F)
            $display("FAIL pattern_bar1: got ok=%b rgb=%h, expected 1 00F", ok, {red, green, blue});
        else n_pass++;
        wait_xy(LAT + 559, 1, ok);
        n_total++;
        if (!ok || {red, green, blue} !== 12'hFF0)
            $display("FAIL pattern_bar6: got ok=%b rgb=%h, expected 1 FF0", ok, {red, green, blue});
        else n_pass++;
        tick();
        n_total++;
        if ({red, green, blue} !== 12'hFFF)
            $display("FAIL pattern_bar7: got rgb=%h, expected FFF", {red, green, blue});
        else n_pass++;
        toggle_rgb = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`else
        test_color(8'hE0, 12'hF00);
        test_color(8'b101_011_10, 12'hB6A);
`endif
        test_hsync();
        test_frames();
        test_midframe_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_sync_gen.md
# vga_sync_gen

Display-timing generator and pixel output stage at the far end of the layered drawing path. It scans 640x480@60 timing, issues pixel coordinates to the object drawers, and accepts the merged 8-bit RGB (3-3-2) returned by the object multiplexer. It realigns that colour with delayed sync and blank signals and drives the VGA DAC pins. It also emits a once-per-frame tick for game-logic updates.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync in lines
- PIPE_DELAY, 2, clocks from a coordinate appearing on pixelX/pixelY to its colour appearing on RGBIn; legal range 0..7
- clk  in  1  pixel clock, 25 MHz nominal
- resetN  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- pixelX  out  11  current horizontal count, 0..799
- pixelY  out  11  current vertical count, 0..524
- frameTick  out  1  one-clock pulse at the start of vertical blanking
- RGBIn  in  8  merged colour {R[2:0],G[2:0],B[1:0]}, valid PIPE_DELAY clocks after its coordinate
- red / green / blue  out  4 each  DAC colour
- hSync / vSync  out  1 each  active-low sync
- blankN  out  1  high while the output pixel is visible

## Operation
- Line length is 800 clocks and frame height is 525 lines. hCount and vCount are registers, and pixelX/pixelY equal them directly.
- hCount increments every clock and wraps 799→0. On that wrap, vCount increments and wraps 524→0.
- visible = (hCount < 640) && (vCount < 480).
- hSyncRaw is low for hCount 656..751. vSyncRaw is low for vCount 490..491.
- frameTick = 1 exactly when hCount==0 && vCount==480.
- Raw {visible, hSyncRaw, vSyncRaw} enter a PIPE_DELAY-deep shift register, so they stay aligned with RGBIn.
- The output stage registers the delayed values:
  - blankN = delayed visible
  - hSync / vSync = delayed raw sync signals
- Colour expansion when delayed visible is 1:
  - red = {R, R[2]}
  - green = {G, G[2]}
  - blue = {B, B}
- When delayed visible is 0, red, green and blue are forced to 0.

## Timing
- Reset values, applied on the first clk edge with resetN low:
  - hCount, vCount, pixelX, pixelY = 0
  - frameTick = 0
  - hSync = 1, vSync = 1
  - blankN = 0
  - red, green, blue = 0
  - delay line flushed to {visible=0, sync=1}
- Reset mid-frame: the same values apply on the next edge. Counting restarts from (0,0) on the first clock with resetN high, and there is no partial-line glitch on the sync outputs.
- Latency from coordinate to pins is PIPE_DELAY+1 clocks. The colour for pixelX=0, pixelY=0 appears on red/green/blue 3 clocks later at default settings.
- hSync falls PIPE_DELAY+1 clocks after hCount reaches 656 and lasts exactly 96 clocks.
- vSync is low for 2×800 clocks.
- With PIPE_DELAY = 0 the delay line is omitted, and latency is 1 clock.
- Frame period is exactly 420000 clocks. frameTick pulses once per frame and is never stretched.

## Configuration
- VGA_TEST_PATTERN_EN defined: RGBIn is ignored.
  - Colour is 8 vertical bars of 80 pixels, with value {3{bar[2]}, 3{bar[1]}, 2{bar[0]}} and bar = pixelX[9:0]/80.
  - The bar value is carried through the same delay line, so alignment is unchanged.
- VGA_TEST_PATTERN_EN undefined: colour comes from RGBIn as described above.

## Structure
- Shared package vga_pkg contains:
  - default timing constants and derived H_TOTAL = 800 and V_TOTAL = 525
  - COORD_W = 11
  - typedef coord_t (logic [10:0])
  - typedef rgb332_t, a packed struct r/g/b
- One sub-module, vga_delay_line: a parameterised width × depth shift register with a synchronous reset value, handling depth 0 as a pass-through.

## Test plan
- Reset for 3 clocks, then release → pixelX/pixelY go 0,1,2… from the first released clock. hSync=1, vSync=1, blankN=0 until PIPE_DELAY+1 clocks after release.
- Hold RGBIn=8'hE0 → red=4'hF, green=0, blue=0 during visible pixels. All colour outputs are 0 on pixels 640..799 and on lines 480..524.
- Measure hSync over one line → low for 96 clocks, falling 659 clocks after hCount=0. Line period is 800 clocks.
- Run 2 frames → frameTick pulses exactly twice, 420000 clocks apart, with vCount=480 at each pulse. vSync is low for 1600 clocks per frame.
- Assert resetN low for 1 clock at hCount=300, vCount=200 → next clock shows all reset values. Counting resumes at (0,0), and the first sync edges occur at the nominal offsets.
- With VGA_TEST_PATTERN_EN and PIPE_DELAY=2 → bar 7 (8'hFF expands to 4'hF on all channels) starts exactly at output pixel 560. Output is independent of RGBIn toggling.
